// File: rtl/upc_breakpoint_ctl_pkg.sv
// upc_breakpoint_ctl_pkg
// Shared definitions for the micro-PC breakpoint controller:
//   - breakpoint FSM state encoding (bp_state_e)
//   - bit positions of the spy control strobe word
//   - default address / counter widths
//   - slice-count helper for the 6-bit compare array
package upc_breakpoint_ctl_pkg;

    localparam int ADDR_W_DEF = 14;
    localparam int CNT_W_DEF  = 8;

    // Width of one equality slice in the address comparator.
    localparam int SLICE_W = 6;

    typedef enum logic [1:0] {
        BP_DISARMED = 2'd0,
        BP_ARMED    = 2'd1,
        BP_HALT     = 2'd2
    } bp_state_e;

    // Bit positions inside spy_data when spy_wr_ctl is strobed.
    localparam int CTL_ARM    = 0;
    localparam int CTL_DISARM = 1;
    localparam int CTL_CLR    = 2;
    localparam int CTL_AUTO   = 3;

    // Number of 6-bit slices needed to cover an address of width w.
    function automatic int num_slices(input int w);
        return (w + SLICE_W - 1) / SLICE_W;
    endfunction

endpackage

// File: rtl/upc_breakpoint_ctl_eq6.sv
// bp_eq6
// One 6-bit enabled equality slice of the breakpoint address comparator.
// Ports:
//   enb_i  in  1  slice enable (breakpoint armed and micro-PC valid)
//   a_i    in  6  micro-PC slice
//   b_i    in  6  breakpoint address slice
//   eq_o   out 1  enb_i & (a_i == b_i)
module bp_eq6 (
    input  logic       enb_i,
    input  logic [5:0] a_i,
    input  logic [5:0] b_i,
    output logic       eq_o
);

    assign eq_o = enb_i & (a_i == b_i);

endmodule

// File: rtl/upc_breakpoint_ctl.sv
// upc_breakpoint_ctl
// Micro-PC breakpoint controller on the spy/debug path. Compares the issued
// micro-PC against a spy-programmed breakpoint address, lets a programmable
// number of matches pass, then raises a halt request held until acknowledged.
//
// State table
//   state       | meaning
//   ------------+---------------------------------------------------------
//   BP_DISARMED | comparator disabled, no halt pending (encoding 3 too)
//   BP_ARMED    | comparing; matches decrement pass count, halt at zero
//   BP_HALT     | halt_req asserted, comparator disabled, waiting halt_ack
//
// Ports:
//   clk           in   1       system clock
//   reset_n       in   1       synchronous reset, active low
//   spy_data      in   16      spy write data
//   spy_wr_addr   in   1       load breakpoint address from spy_data
//   spy_wr_count  in   1       load pass-reload value from spy_data
//   spy_wr_ctl    in   1       control strobe (arm/disarm/clear/auto-rearm)
//   upc           in   ADDR_W  current micro-PC
//   upc_valid     in   1       upc issued this cycle
//   halt_ack      in   1       processor has stopped (pulse)
//   halt_req      out  1       registered halt request
//   bp_state      out  2       0 DISARMED, 1 ARMED, 2 HALT
//   captured_upc  out  ADDR_W  micro-PC that caused the halt
//   match_tally   out  CNT_W   saturating count of qualified matches
//   bp_match      out  1       combinational qualified match, for trace
module upc_breakpoint_ctl
    import upc_breakpoint_ctl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [15:0]       spy_data,
    input  logic              spy_wr_addr,
    input  logic              spy_wr_count,
    input  logic              spy_wr_ctl,
    input  logic [ADDR_W-1:0] upc,
    input  logic              upc_valid,
    input  logic              halt_ack,
    output logic              halt_req,
    output logic [1:0]        bp_state,
    output logic [ADDR_W-1:0] captured_upc,
    output logic [CNT_W-1:0]  match_tally,
    output logic              bp_match
);

    localparam int NSL   = num_slices(ADDR_W);
    localparam int PAD_W = NSL * SLICE_W;

    bp_state_e         state_q, state_d;
    logic [ADDR_W-1:0] bp_addr_q, bp_addr_d;
    logic [CNT_W-1:0]  pass_reload_q, pass_reload_d;
    logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d;
    logic              auto_rearm_q, auto_rearm_d;
    logic              halt_req_q, halt_req_d;
    logic [ADDR_W-1:0] captured_q, captured_d;
    logic [CNT_W-1:0]  tally_q, tally_d;

    // Spy data bits above the widest field are never consumed.
    logic unused_spy_bits;
    assign unused_spy_bits = ^spy_data;

    // ------------------------------------------------------------------
    // Sliced comparator. Both operands are zero-padded so the unused top
    // bits of the last slice always compare equal.
    // ------------------------------------------------------------------
    logic [PAD_W-1:0] upc_pad;
    logic [PAD_W-1:0] bp_pad;
    logic [NSL-1:0]   slice_eq;
    logic             slice_enb;

    assign upc_pad   = PAD_W'(upc);
    assign bp_pad    = PAD_W'(bp_addr_q);
    assign slice_enb = (state_q == BP_ARMED) & upc_valid;

    for (genvar i = 0; i < NSL; i++) begin : g_slice
        bp_eq6 u_eq (
            .enb_i (slice_enb),
            .a_i   (upc_pad[i*SLICE_W +: SLICE_W]),
            .b_i   (bp_pad[i*SLICE_W +: SLICE_W]),
            .eq_o  (slice_eq[i])
        );
    end

    // Every slice is gated by the same enable, so the AND is already
    // qualified by ARMED & upc_valid.
    assign bp_match = &slice_eq;

    // A disarm strobe in the same cycle suppresses the match entirely:
    // no halt, no tally increment, no pass-count movement.
    logic ctl_disarm;
    logic ctl_arm;
    logic match_go;

    assign ctl_disarm = spy_wr_ctl & spy_data[CTL_DISARM];
    assign ctl_arm    = spy_wr_ctl & spy_data[CTL_ARM] & ~spy_data[CTL_DISARM];
    assign match_go   = bp_match & ~ctl_disarm;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        bp_addr_d     = bp_addr_q;
        pass_reload_d = pass_reload_q;
        pass_cnt_d    = pass_cnt_q;
        auto_rearm_d  = auto_rearm_q;
        halt_req_d    = halt_req_q;
        captured_d    = captured_q;
        tally_d       = tally_q;

        case (state_q)
            BP_ARMED: begin
                if (match_go) begin
                    if (tally_q != '1) begin
                        tally_d = tally_q + CNT_W'(1);
                    end
                    if (pass_cnt_q != '0) begin
                        pass_cnt_d = pass_cnt_q - CNT_W'(1);
                    end else begin
                        state_d    = BP_HALT;
                        halt_req_d = 1'b1;
                        captured_d = upc;
                    end
                end
            end
            BP_HALT: begin
                if (halt_ack) begin
                    halt_req_d = 1'b0;
                    if (auto_rearm_q) begin
                        state_d    = BP_ARMED;
                        pass_cnt_d = pass_reload_q;
                    end else begin
                        state_d = BP_DISARMED;
                    end
                end
            end
            default: begin
                // Covers DISARMED and the unreachable encoding 3.
                state_d = BP_DISARMED;
            end
        endcase

        // Spy control writes override the FSM. halt_req only ever stays
        // high while the state is HALT, so arm/disarm both drop it.
        if (spy_wr_ctl) begin
            auto_rearm_d = spy_data[CTL_AUTO];
            if (ctl_disarm) begin
                state_d    = BP_DISARMED;
                halt_req_d = 1'b0;
            end else if (ctl_arm) begin
                state_d    = BP_ARMED;
                halt_req_d = 1'b0;
                pass_cnt_d = pass_reload_q;
            end
            if (spy_data[CTL_CLR]) begin
                tally_d = '0;
            end
        end

        if (spy_wr_addr) begin
            bp_addr_d = spy_data[ADDR_W-1:0];
        end
        if (spy_wr_count) begin
            pass_reload_d = spy_data[CNT_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= BP_DISARMED;
            bp_addr_q     <= '0;
            pass_reload_q <= '0;
            pass_cnt_q    <= '0;
            auto_rearm_q  <= 1'b0;
            halt_req_q    <= 1'b0;
            captured_q    <= '0;
            tally_q       <= '0;
        end else begin
            state_q       <= state_d;
            bp_addr_q     <= bp_addr_d;
            pass_reload_q <= pass_reload_d;
            pass_cnt_q    <= pass_cnt_d;
            auto_rearm_q  <= auto_rearm_d;
            halt_req_q    <= halt_req_d;
            captured_q    <= captured_d;
            tally_q       <= tally_d;
        end
    end

    assign halt_req     = halt_req_q;
    assign bp_state     = state_q;
    assign captured_upc = captured_q;
    assign match_tally  = tally_q;

endmodule

// File: tb/tb_upc_breakpoint_ctl.sv
// Directed self-checking bench for upc_breakpoint_ctl.
module tb_upc_breakpoint_ctl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] spy_data;
    logic        spy_wr_addr;
    logic        spy_wr_count;
    logic        spy_wr_ctl;
    logic [13:0] upc;
    logic        upc_valid;
    logic        halt_ack;
    logic        halt_req;
    logic [1:0]  bp_state;
    logic [13:0] captured_upc;
    logic [7:0]  match_tally;
    logic        bp_match;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    upc_breakpoint_ctl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .spy_data     (spy_data),
        .spy_wr_addr  (spy_wr_addr),
        .spy_wr_count (spy_wr_count),
        .spy_wr_ctl   (spy_wr_ctl),
        .upc          (upc),
        .upc_valid    (upc_valid),
        .halt_ack     (halt_ack),
        .halt_req     (halt_req),
        .bp_state     (bp_state),
        .captured_upc (captured_upc),
        .match_tally  (match_tally),
        .bp_match     (bp_match)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_addr(input logic [15:0] d);
        spy_data = d; spy_wr_addr = 1'b1;
        tick;
        spy_wr_addr = 1'b0; spy_data = '0;
    endtask

    task automatic wr_count(input logic [15:0] d);
        spy_data = d; spy_wr_count = 1'b1;
        tick;
        spy_wr_count = 1'b0; spy_data = '0;
    endtask

    task automatic wr_ctl(input logic [15:0] d);
        spy_data = d; spy_wr_ctl = 1'b1;
        tick;
        spy_wr_ctl = 1'b0; spy_data = '0;
    endtask

    task automatic ack_pulse;
        halt_ack = 1'b1;
        tick;
        halt_ack = 1'b0;
    endtask

    // Present one upc for one cycle, check the combinational match mid-cycle.
    task automatic drive_upc(input logic [13:0] u, input logic v, input logic exp_m);
        upc = u; upc_valid = v;
        #1;
        chk("bp_match", {31'd0, bp_match}, {31'd0, exp_m});
        @(posedge clk);
        #1;
        upc_valid = 1'b0;
    endtask

    task automatic chk_status(input string tag, input logic [1:0] st, input logic hr,
                              input logic [7:0] tally);
        chk({tag, ".state"}, 32'(bp_state), 32'(st));
        chk({tag, ".halt_req"}, 32'(halt_req), 32'(hr));
        chk({tag, ".tally"}, 32'(match_tally), 32'(tally));
    endtask

    initial begin
        reset_n = 1'b0; spy_data = '0; spy_wr_addr = 1'b0; spy_wr_count = 1'b0;
        spy_wr_ctl = 1'b0; upc = '0; upc_valid = 1'b0; halt_ack = 1'b0;
        tick; tick;
        reset_n = 1'b1;
        chk_status("reset", 2'd0, 1'b0, 8'd0);
        chk("reset.captured", 32'(captured_upc), 32'h0);

        // Single-shot breakpoint at 0x1234
        wr_addr(16'h1234);
        wr_count(16'h0000);
        wr_ctl(16'h0001);
        chk("arm.state", 32'(bp_state), 32'd1);
        drive_upc(14'h1233, 1'b1, 1'b0);
        chk_status("near_miss", 2'd1, 1'b0, 8'd0);
        drive_upc(14'h1234, 1'b1, 1'b1);
        chk_status("hit1234", 2'd2, 1'b1, 8'd1);
        chk("hit1234.captured", 32'(captured_upc), 32'h1234);

        // HALT holds without ack; further matching upc ignored
        for (int i = 0; i < 5; i++) begin
            drive_upc(14'h1234, 1'b1, 1'b0);
            chk_status("halt_hold", 2'd2, 1'b1, 8'd1);
        end
        ack_pulse;
        chk_status("ack_noauto", 2'd0, 1'b0, 8'd1);

        // Top slice differs / upc_valid low
        wr_ctl(16'h0001);
        drive_upc(14'h3234, 1'b1, 1'b0);
        drive_upc(14'h1234, 1'b0, 1'b0);
        chk_status("no_match", 2'd1, 1'b0, 8'd1);

        // Tally clear while armed
        wr_ctl(16'h0004);
        chk_status("clear", 2'd1, 1'b0, 8'd0);

        // Pass count 2, auto-rearm
        wr_addr(16'h0100);
        wr_count(16'h0002);
        wr_ctl(16'h0009);
        drive_upc(14'h0100, 1'b1, 1'b1);
        chk_status("pass1", 2'd1, 1'b0, 8'd1);
        drive_upc(14'h0100, 1'b1, 1'b1);
        chk_status("pass2", 2'd1, 1'b0, 8'd2);
        drive_upc(14'h0100, 1'b1, 1'b1);
        chk_status("pass3", 2'd2, 1'b1, 8'd3);
        chk("pass3.captured", 32'(captured_upc), 32'h0100);
        ack_pulse;
        chk_status("ack_auto", 2'd1, 1'b0, 8'd3);
        drive_upc(14'h0100, 1'b1, 1'b1);
        drive_upc(14'h0100, 1'b1, 1'b1);
        chk_status("reload2", 2'd1, 1'b0, 8'd5);
        drive_upc(14'h0100, 1'b1, 1'b1);
        chk_status("reload3", 2'd2, 1'b1, 8'd6);

        // Disarm from HALT abandons the halt
        wr_ctl(16'h0002);
        chk_status("disarm_halt", 2'd0, 1'b0, 8'd6);

        // Disarm strobe and match in the same cycle
        wr_ctl(16'h0001);
        spy_data = 16'h0002; spy_wr_ctl = 1'b1;
        drive_upc(14'h0100, 1'b1, 1'b1);
        spy_wr_ctl = 1'b0; spy_data = '0;
        chk_status("disarm_race", 2'd0, 1'b0, 8'd6);

        // Address write and match on old address in the same cycle
        wr_count(16'h0000);
        wr_ctl(16'h0001);
        spy_data = 16'h0200; spy_wr_addr = 1'b1;
        drive_upc(14'h0100, 1'b1, 1'b1);
        spy_wr_addr = 1'b0; spy_data = '0;
        chk_status("addr_race", 2'd2, 1'b1, 8'd7);
        chk("addr_race.captured", 32'(captured_upc), 32'h0100);

        // Reset in HALT
        reset_n = 1'b0;
        tick;
        reset_n = 1'b1;
        chk_status("reset_halt", 2'd0, 1'b0, 8'd0);
        chk("reset_halt.captured", 32'(captured_upc), 32'h0);
        // bp_addr and pass_reload were cleared: arm and hit upc 0 at once
        wr_ctl(16'h0001);
        drive_upc(14'h0000, 1'b1, 1'b1);
        chk_status("post_reset_hit", 2'd2, 1'b1, 8'd1);
        ack_pulse;
        chk_status("post_reset_ack", 2'd0, 1'b0, 8'd1);
        ack_pulse;
        chk_status("ack_outside", 2'd0, 1'b0, 8'd1);

        // Tally saturation with pass count 255
        wr_count(16'h00FF);
        wr_ctl(16'h0005);
        chk_status("sat_start", 2'd1, 1'b0, 8'd0);
        for (int i = 0; i < 255; i++) begin
            drive_upc(14'h0000, 1'b1, 1'b1);
        end
        chk_status("sat_255", 2'd1, 1'b0, 8'd255);
        drive_upc(14'h0000, 1'b1, 1'b1);
        chk_status("sat_256", 2'd2, 1'b1, 8'd255);
        for (int i = 0; i < 44; i++) begin
            drive_upc(14'h0000, 1'b1, 1'b0);
        end
        chk_status("sat_300", 2'd2, 1'b1, 8'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
